rans_sched: RTL and testbench
=============================

Name: rans_sched

Overview:
- Front-end controller for the 4-lane rANS encoder array.
- Loads the symbol frequency table into the datapath. Each entry is written with a freq_wr pulse, and the block honours the datapath's 4-cycle busy window.
- Computes cumulative frequencies on the fly and checks that the table sums to 2^RESOLUTION.
- Streams symbols to the datapath with valid/ready, tags each symbol with a round-robin lane index, and flushes at end of stream.

Parameters:
- RESOLUTION, 10, log2 of the total frequency; freq/cum width is RESOLUTION+1.
- SYMBOL_WIDTH, 8, symbol width; alphabet size ALPHABET = 2^SYMBOL_WIDTH.
- FLUSH_CYCLES, 8, idle cycles after the last symbol before done_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cfg_start_i  in  1  begin table load.
- freq_valid_i  in  1  table entry valid.
- freq_ready_o  out  1  table entry accepted.
- freq_data_i  in  RESOLUTION+1  frequency of the next symbol (symbols 0..ALPHABET-1 in order).
- sym_valid_i  in  1  symbol valid.
- sym_ready_o  out  1  symbol accepted.
- sym_i  in  SYMBOL_WIDTH  symbol.
- sym_last_i  in  1  last symbol of stream.
- dp_ready_i  in  1  datapath ready (low for 3 cycles after freq_wr).
- dp_freq_wr_o  out  1  table write pulse.
- dp_freq_o  out  RESOLUTION+1  frequency.
- dp_cum_freq_o  out  RESOLUTION+1  cumulative frequency.
- dp_symb_o  out  SYMBOL_WIDTH  table index in LOAD, symbol in RUN.
- dp_en_o  out  1  symbol-issue pulse.
- dp_lane_o  out  2  lane tag for the issued symbol.
- busy_o  out  1  state is not IDLE/RUN/ERR.
- done_o  out  1  one-cycle pulse at end of FLUSH.
- err_o  out  1  table error, sticky.
- sym_cnt_o  out  32  accepted-symbol count.
- stall_cnt_o  out  32  RUN stall cycles.

Behaviour:
- Reset (synchronous, one clock with rst_i high):
  - State = IDLE.
  - All outputs 0, including index, cum accumulator and lane counter.
  - Reset mid-operation abandons any load or stream. The table is considered unloaded.
- States: IDLE, LOAD, CHECK, RUN, FLUSH, ERR.
- Transition to LOAD:
  - cfg_start_i in IDLE, RUN or ERR -> LOAD.
  - On entry: index=0, cum=0, err_o cleared, lane=0.
  - cfg_start_i is ignored in LOAD, CHECK and FLUSH.
  - In RUN, cfg_start_i has priority: sym_ready_o is forced low that cycle.
- LOAD:
  - freq_ready_o = dp_ready_i && !dp_freq_wr_o.
  - On handshake, in the next cycle: dp_freq_wr_o=1, dp_freq_o=freq_data_i, dp_cum_freq_o=cum, dp_symb_o=index. Then cum += freq_data_i and index++.
  - The next entry is never accepted before dp_ready_i returns high, so consecutive freq_wr pulses are ≥4 cycles apart when the datapath behaves.
  - After index ALPHABET-1 is written -> CHECK.
- Overflow flag:
  - Set if freq_data_i > 2^RESOLUTION.
  - Set if the cum accumulator (RESOLUTION+2 bits internally) exceeds 2^RESOLUTION.
  - Zero frequencies are legal.
- CHECK (1 cycle):
  - If cum == 2^RESOLUTION and no overflow -> RUN.
  - Otherwise -> ERR with err_o=1.
- ERR: no outputs toggle. Leaves only via cfg_start_i or reset.
- RUN:
  - sym_ready_o = dp_ready_i && !cfg_start_i.
  - On handshake, in the next cycle: dp_en_o=1, dp_symb_o=sym_i, dp_lane_o=lane. Then lane increments modulo 4 (3 wraps to 0).
  - Back-to-back symbols at 1 per cycle.
  - Handshake with sym_last_i=1 -> FLUSH.
- FLUSH:
  - sym_ready_o=0, dp_en_o=0 for FLUSH_CYCLES cycles.
  - Then a done_o pulse and -> RUN. The table stays loaded; lane is not reset.
- dp_freq_wr_o and dp_en_o are never high in the same cycle.

Optional Feature:
- RANS_SCHED_STATS_EN defined:
  - sym_cnt_o counts RUN handshakes.
  - stall_cnt_o counts RUN cycles with sym_valid_i && !sym_ready_o.
  - Both are 32-bit, saturate at all-ones, and clear on cfg_start_i acceptance and on reset.
- Not defined: both tied to 0. Ports are always present.

Decomposition:
- Shared rans_pkg:
  - State enum.
  - ALPHABET, FREQ_W=RESOLUTION+1 and TOTAL=2^RESOLUTION as functions of the parameters.
  - NUM_LANES=4 and lane index type.
- One sub-module, rans_freq_acc:
  - Cum accumulator, index counter and overflow/sum check.
  - Interfaces: clear, step, freq in; cum, index, last, ok out.

Test Plan (RESOLUTION=10, SYMBOL_WIDTH=2 unless noted):
- Load 256,256,256,256 with a datapath model dropping ready 3 cycles per write -> freq_wr pulses carry cum 0,256,512,768 and idx 0..3, spaced ≥4 cycles; CHECK->RUN; err_o=0.
- Load 300,256,256,256 -> sum 1068 -> ERR, err_o=1, sym_ready_o=0. Then cfg_start_i and a valid table -> RUN, err_o=0.
- Load 1025,0,0,0 -> overflow -> err_o=1.
- Stream 5 symbols back-to-back, last on the 5th -> dp_en_o 5 consecutive cycles, lanes 0,1,2,3,0. FLUSH 8 cycles, then one done_o pulse.
- Assert rst_i after 2 table entries -> outputs 0 next cycle, IDLE, no further freq_wr. Then cfg_start_i reloads from idx 0.
- With RANS_SCHED_STATS_EN, hold dp_ready_i low 3 cycles while sym_valid_i=1, then accept 4 symbols -> stall_cnt_o=3, sym_cnt_o=4.

Source files
------------

// File: rtl/rans_sched_pkg.sv
// rans_sched_pkg: shared types and sizing helpers for the rANS front-end
// scheduler.
// Contents:
//   state_t                 scheduler FSM states
//   NUM_LANES, lane_t       encoder lane count and lane tag type
//   alphabet_f, freq_w_f,   ALPHABET, FREQ_W and TOTAL as functions of
//   total_f                 SYMBOL_WIDTH / RESOLUTION
package rans_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_RUN,
        ST_FLUSH,
        ST_ERR
    } state_t;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = $clog2(NUM_LANES);
    typedef logic [LANE_W-1:0] lane_t;

    // ALPHABET = 2^SYMBOL_WIDTH
    function automatic int alphabet_f(input int sym_w);
        return 1 << sym_w;
    endfunction

    // FREQ_W = RESOLUTION + 1, wide enough to hold TOTAL itself
    function automatic int freq_w_f(input int res);
        return res + 1;
    endfunction

    // TOTAL = 2^RESOLUTION, the required table sum
    function automatic int total_f(input int res);
        return 1 << res;
    endfunction

endpackage

// File: rtl/rans_sched_if.sv
// rans_sched_if: table-load, symbol-stream and datapath signals of the
// rANS scheduler.
//   slave  : the scheduler side (consumes freq/sym streams, drives datapath)
//   master : the environment side (sources streams, models the datapath)
// Signals:
//   freq_valid_i/freq_ready_o/freq_data_i  table entry stream
//   sym_valid_i/sym_ready_o/sym_i/sym_last_i  symbol stream
//   dp_ready_i                             datapath ready
//   dp_freq_wr_o/dp_freq_o/dp_cum_freq_o   table write to datapath
//   dp_symb_o                              table index (load) / symbol (run)
//   dp_en_o/dp_lane_o                      symbol issue and lane tag
interface rans_sched_if
    import rans_sched_pkg::*;
#(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8
);
    logic                    freq_valid_i;
    logic                    freq_ready_o;
    logic [RESOLUTION:0]     freq_data_i;
    logic                    sym_valid_i;
    logic                    sym_ready_o;
    logic [SYMBOL_WIDTH-1:0] sym_i;
    logic                    sym_last_i;
    logic                    dp_ready_i;
    logic                    dp_freq_wr_o;
    logic [RESOLUTION:0]     dp_freq_o;
    logic [RESOLUTION:0]     dp_cum_freq_o;
    logic [SYMBOL_WIDTH-1:0] dp_symb_o;
    logic                    dp_en_o;
    lane_t                   dp_lane_o;

    modport slave (
        input  freq_valid_i, freq_data_i, sym_valid_i, sym_i, sym_last_i,
               dp_ready_i,
        output freq_ready_o, sym_ready_o, dp_freq_wr_o, dp_freq_o,
               dp_cum_freq_o, dp_symb_o, dp_en_o, dp_lane_o
    );

    modport master (
        output freq_valid_i, freq_data_i, sym_valid_i, sym_i, sym_last_i,
               dp_ready_i,
        input  freq_ready_o, sym_ready_o, dp_freq_wr_o, dp_freq_o,
               dp_cum_freq_o, dp_symb_o, dp_en_o, dp_lane_o
    );

endinterface

// File: rtl/rans_sched_freq_acc.sv
// rans_freq_acc: cumulative-frequency accumulator and table checker.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   clear_i        restart a table (index=0, cum=0, overflow cleared)
//   step_i         accept one table entry freq_i
//   freq_i         frequency of the entry at index_o
//   cum_o          cumulative frequency before the current entry
//   index_o        index of the next entry
//   last_o         next entry is the final one (ALPHABET-1)
//   ok_o           sum equals TOTAL and nothing overflowed
module rans_freq_acc
    import rans_sched_pkg::*;
#(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    step_i,
    input  logic [RESOLUTION:0]     freq_i,
    output logic [RESOLUTION:0]     cum_o,
    output logic [SYMBOL_WIDTH-1:0] index_o,
    output logic                    last_o,
    output logic                    ok_o
);
    localparam int FREQ_W   = freq_w_f(RESOLUTION);
    localparam int CUM_W    = RESOLUTION + 2;
    localparam int TOTAL    = total_f(RESOLUTION);
    localparam int ALPHABET = alphabet_f(SYMBOL_WIDTH);

    logic [CUM_W-1:0]        cum_q, cum_d, sum;
    logic [SYMBOL_WIDTH-1:0] idx_q, idx_d;
    logic                    ovf_q, ovf_d;

    // One extra bit over FREQ_W: cum <= TOTAL until overflow is flagged, so
    // cum + freq cannot wrap before the sticky flag catches it.
    assign sum = cum_q + CUM_W'(freq_i);

    always_comb begin
        cum_d = cum_q;
        idx_d = idx_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            cum_d = '0;
            idx_d = '0;
            ovf_d = 1'b0;
        end else if (step_i) begin
            cum_d = sum;
            idx_d = idx_q + SYMBOL_WIDTH'(1);
            if (freq_i > FREQ_W'(TOTAL) || sum > CUM_W'(TOTAL))
                ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cum_q <= '0;
            idx_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cum_q <= cum_d;
            idx_q <= idx_d;
            ovf_q <= ovf_d;
        end
    end

    assign cum_o   = cum_q[FREQ_W-1:0];
    assign index_o = idx_q;
    assign last_o  = (idx_q == SYMBOL_WIDTH'(ALPHABET - 1));
    assign ok_o    = (cum_q == CUM_W'(TOTAL)) && !ovf_q;

endmodule

// File: rtl/rans_sched.sv
// rans_sched: front-end controller for the 4-lane rANS encoder array.
// Loads the frequency table into the datapath (respecting its busy window),
// verifies the table sums to 2^RESOLUTION, then streams symbols with a
// round-robin lane tag and flushes FLUSH_CYCLES cycles at end of stream.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   cfg_start_i        begin table load (honoured in IDLE, RUN, ERR)
//   bus                rans_sched_if.slave: freq/sym streams + datapath
//   busy_o             in LOAD, CHECK or FLUSH
//   done_o             one-cycle pulse when FLUSH completes
//   err_o              sticky table error, cleared by a new load
//   sym_cnt_o          accepted symbols      (RANS_SCHED_STATS_EN only)
//   stall_cnt_o        RUN stall cycles      (RANS_SCHED_STATS_EN only)
// Build option: define RANS_SCHED_STATS_EN to enable the statistics
// counters; otherwise both counter outputs read 0.
module rans_sched
    import rans_sched_pkg::*;
#(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cfg_start_i,
    rans_sched_if.slave bus,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] sym_cnt_o,
    output logic [31:0] stall_cnt_o
);
    localparam int FREQ_W  = freq_w_f(RESOLUTION);
    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t                  state_q, state_d;
    logic                    wr_q, wr_d, en_q, en_d, done_q, done_d;
    logic                    err_q, err_d;
    logic [FREQ_W-1:0]       dfreq_q, dfreq_d, dcum_q, dcum_d;
    logic [SYMBOL_WIDTH-1:0] symb_q, symb_d;
    lane_t                   lane_q, lane_d, lane_out_q, lane_out_d;
    logic [FLUSH_W-1:0]      flush_q, flush_d;

    logic                    freq_ready, sym_ready, freq_hs, sym_hs, start_ok;
    logic [FREQ_W-1:0]       acc_cum;
    logic [SYMBOL_WIDTH-1:0] acc_idx;
    logic                    acc_last, acc_ok;

    // The cycle carrying a write pulse is also blocked, so the datapath has
    // a chance to drop ready before the next entry can be taken.
    assign freq_ready = (state_q == ST_LOAD) && bus.dp_ready_i && !wr_q;
    // A restart request wins over a symbol in the same cycle.
    assign sym_ready  = (state_q == ST_RUN) && bus.dp_ready_i && !cfg_start_i;
    assign freq_hs    = freq_ready && bus.freq_valid_i;
    assign sym_hs     = sym_ready && bus.sym_valid_i;
    assign start_ok   = cfg_start_i &&
                        (state_q == ST_IDLE || state_q == ST_RUN || state_q == ST_ERR);

    rans_freq_acc #(
        .RESOLUTION  (RESOLUTION),
        .SYMBOL_WIDTH(SYMBOL_WIDTH)
    ) u_acc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(start_ok),
        .step_i (freq_hs),
        .freq_i (bus.freq_data_i),
        .cum_o  (acc_cum),
        .index_o(acc_idx),
        .last_o (acc_last),
        .ok_o   (acc_ok)
    );

    always_comb begin
        state_d    = state_q;
        wr_d       = 1'b0;
        en_d       = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q;
        dfreq_d    = dfreq_q;
        dcum_d     = dcum_q;
        symb_d     = symb_q;
        lane_d     = lane_q;
        lane_out_d = lane_out_q;
        flush_d    = flush_q;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start_ok) begin
                    state_d = ST_LOAD;
                    err_d   = 1'b0;
                    lane_d  = '0;
                end
            end
            ST_LOAD: begin
                if (freq_hs) begin
                    wr_d    = 1'b1;
                    dfreq_d = bus.freq_data_i;
                    dcum_d  = acc_cum;
                    symb_d  = acc_idx;
                    if (acc_last) state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (acc_ok) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_ERR;
                    err_d   = 1'b1;
                end
            end
            ST_RUN: begin
                if (start_ok) begin
                    state_d = ST_LOAD;
                    err_d   = 1'b0;
                    lane_d  = '0;
                end else if (sym_hs) begin
                    en_d       = 1'b1;
                    symb_d     = bus.sym_i;
                    lane_out_d = lane_q;
                    lane_d     = lane_q + lane_t'(1);
                    if (bus.sym_last_i) begin
                        state_d = ST_FLUSH;
                        flush_d = '0;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                    flush_d = '0;
                end else begin
                    flush_d = flush_q + FLUSH_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dfreq_q    <= '0;
            dcum_q     <= '0;
            symb_q     <= '0;
            lane_q     <= '0;
            lane_out_q <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            en_q       <= en_d;
            done_q     <= done_d;
            err_q      <= err_d;
            dfreq_q    <= dfreq_d;
            dcum_q     <= dcum_d;
            symb_q     <= symb_d;
            lane_q     <= lane_d;
            lane_out_q <= lane_out_d;
            flush_q    <= flush_d;
        end
    end

`ifdef RANS_SCHED_STATS_EN
    logic [31:0] sym_cnt_q, sym_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        sym_cnt_d   = sym_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (start_ok) begin
            sym_cnt_d   = '0;
            stall_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            if (sym_hs && sym_cnt_q != '1)
                sym_cnt_d = sym_cnt_q + 32'd1;
            if (bus.sym_valid_i && !sym_ready && stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sym_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            sym_cnt_q   <= sym_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sym_cnt_o   = sym_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign sym_cnt_o   = '0;
    assign stall_cnt_o = '0;
`endif

    assign bus.freq_ready_o  = freq_ready;
    assign bus.sym_ready_o   = sym_ready;
    assign bus.dp_freq_wr_o  = wr_q;
    assign bus.dp_freq_o     = dfreq_q;
    assign bus.dp_cum_freq_o = dcum_q;
    assign bus.dp_symb_o     = symb_q;
    assign bus.dp_en_o       = en_q;
    assign bus.dp_lane_o     = lane_out_q;
    assign busy_o = (state_q == ST_LOAD) || (state_q == ST_CHECK) || (state_q == ST_FLUSH);
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_rans_sched.sv
// tb_rans_sched: self-checking bench for rans_sched (RESOLUTION=10,
// SYMBOL_WIDTH=2, FLUSH_CYCLES=8). A datapath model drops ready for three
// cycles after each table write; monitors log write/issue/done pulses with
// their cycle numbers, and each test compares them with expectations derived
// from table sums, lane rotation and flush length.
module tb_rans_sched;
    localparam int RES = 10;
    localparam int SW  = 2;
    localparam int FC  = 8;
    localparam int TOT = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic        busy, done, err;
    logic [31:0] sym_cnt, stall_cnt;
    logic        force_low;
    int          dp_cnt = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          both_hi = 0;
    int          lane_model = 0;
    int          tbl[4];

    typedef struct { int cyc; int freq; int cum; int symb; } wr_ev_t;
    typedef struct { int cyc; int symb; int lane; } en_ev_t;
    wr_ev_t wrq[$];
    en_ev_t enq[$];
    int     doneq[$];

    rans_sched_if #(.RESOLUTION(RES), .SYMBOL_WIDTH(SW)) b ();

    rans_sched #(.RESOLUTION(RES), .SYMBOL_WIDTH(SW), .FLUSH_CYCLES(FC)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cfg_start_i(cfg_start),
        .bus        (b),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .sym_cnt_o  (sym_cnt),
        .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    // Datapath model: busy for 3 cycles after each table write.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (b.dp_freq_wr_o) dp_cnt <= 3;
        else if (dp_cnt != 0) dp_cnt <= dp_cnt - 1;
    end
    assign b.dp_ready_i = (dp_cnt == 0) && !force_low;

    always @(negedge clk) begin
        if (b.dp_freq_wr_o)
            wrq.push_back('{cyc, int'(b.dp_freq_o), int'(b.dp_cum_freq_o), int'(b.dp_symb_o)});
        if (b.dp_en_o)
            enq.push_back('{cyc, int'(b.dp_symb_o), int'(b.dp_lane_o)});
        if (done) doneq.push_back(cyc);
        if (b.dp_freq_wr_o && b.dp_en_o) both_hi++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        lane_model = 0;
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            int  k;
            bit  taken;
            b.freq_valid_i = 1'b1;
            b.freq_data_i  = 11'(tbl[i]);
            k = 0;
            taken = 1'b0;
            while (!taken && k < 50) begin
                #1 taken = b.freq_ready_o;
                @(negedge clk);
                k++;
            end
            if (!taken) begin
                checks++; errors++;
                $display("FAIL feed_timeout: entry %0d not accepted", i);
            end
        end
        b.freq_valid_i = 1'b0;
    endtask

    task automatic send_syms(input int n, input int s[8], input bit last_on_end);
        for (int i = 0; i < n; i++) begin
            int k;
            bit taken;
            b.sym_valid_i = 1'b1;
            b.sym_i       = 2'(s[i]);
            b.sym_last_i  = last_on_end && (i == n - 1);
            k = 0;
            taken = 1'b0;
            while (!taken && k < 50) begin
                #1 taken = b.sym_ready_o;
                @(negedge clk);
                k++;
            end
            if (!taken) begin
                checks++; errors++;
                $display("FAIL sym_timeout: symbol %0d not accepted", i);
            end
        end
        b.sym_valid_i = 1'b0;
        b.sym_last_i  = 1'b0;
    endtask

    task automatic rand_valid_table();
        int a, c, d;
        a = int'($urandom_range(0, TOT));
        c = int'($urandom_range(0, TOT - a));
        d = int'($urandom_range(0, TOT - a - c));
        tbl = '{a, c, d, TOT - a - c - d};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({b.dp_freq_wr_o, b.dp_en_o, busy, done, err, b.freq_ready_o, b.sym_ready_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0", {b.dp_freq_wr_o, b.dp_en_o, busy, done, err});
        end
        checks++;
        if ({b.dp_freq_o, b.dp_cum_freq_o, b.dp_symb_o, b.dp_lane_o, sym_cnt, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_data: freq %0d cum %0d symb %0d required 0",
                     b.dp_freq_o, b.dp_cum_freq_o, b.dp_symb_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_load();
        for (int t = 0; t < 4; t++) begin
            int exp_cum;
            if (t == 0) tbl = '{256, 256, 256, 256};
            else rand_valid_table();
            wrq.delete();
            do_start();
            feed(4);
            repeat (8) @(negedge clk);
            checks++;
            if (wrq.size() != 4) begin
                errors++;
                $display("FAIL load_wr_count: got %0d required 4", wrq.size());
            end else begin
                exp_cum = 0;
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (wrq[i].freq != tbl[i] || wrq[i].cum != exp_cum || wrq[i].symb != i) begin
                        errors++;
                        $display("FAIL load_entry%0d: got f=%0d c=%0d i=%0d required f=%0d c=%0d i=%0d",
                                 i, wrq[i].freq, wrq[i].cum, wrq[i].symb, tbl[i], exp_cum, i);
                    end
                    if (i > 0) begin
                        checks++;
                        if (wrq[i].cyc - wrq[i-1].cyc < 4) begin
                            errors++;
                            $display("FAIL load_spacing%0d: got %0d required >=4", i, wrq[i].cyc - wrq[i-1].cyc);
                        end
                    end
                    exp_cum += tbl[i];
                end
            end
            checks++;
            if (err !== 1'b0 || busy !== 1'b0 || b.sym_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL load_run: got err=%b busy=%b ready=%b required 0 0 1", err, busy, b.sym_ready_o);
            end
        end
    endtask

    task automatic test_error();
        for (int t = 0; t < 4; t++) begin
            int  sum;
            bit  exp_err;
            if (t == 0) tbl = '{300, 256, 256, 256};
            else if (t == 1) tbl = '{1025, 0, 0, 0};
            else begin
                for (int i = 0; i < 4; i++) tbl[i] = int'($urandom_range(0, 1200));
                if (tbl[0] + tbl[1] + tbl[2] + tbl[3] == TOT) tbl[0] = tbl[0] + 1;
            end
            sum = 0;
            exp_err = 1'b0;
            for (int i = 0; i < 4; i++) begin
                sum += tbl[i];
                if (tbl[i] > TOT) exp_err = 1'b1;
            end
            if (sum != TOT) exp_err = 1'b1;
            do_start();
            feed(4);
            repeat (8) @(negedge clk);
            checks++;
            if (err !== exp_err || b.sym_ready_o !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL err_table%0d: got err=%b ready=%b busy=%b required %b 0 0",
                         t, err, b.sym_ready_o, busy, exp_err);
            end
        end
        // ERR must hold still even with symbols offered.
        wrq.delete();
        enq.delete();
        b.sym_valid_i = 1'b1;
        repeat (5) @(negedge clk);
        b.sym_valid_i = 1'b0;
        checks++;
        if (wrq.size() != 0 || enq.size() != 0 || err !== 1'b1) begin
            errors++;
            $display("FAIL err_quiet: got wr=%0d en=%0d err=%b required 0 0 1", wrq.size(), enq.size(), err);
        end
        rand_valid_table();
        do_start();
        feed(4);
        repeat (8) @(negedge clk);
        checks++;
        if (err !== 1'b0 || b.sym_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL err_recover: got err=%b ready=%b required 0 1", err, b.sym_ready_o);
        end
    endtask

    task automatic test_stream();
        for (int r = 0; r < 4; r++) begin
            int n;
            int s[8];
            n = (r == 0) ? 5 : int'($urandom_range(1, 7));
            for (int i = 0; i < 8; i++) s[i] = int'($urandom_range(0, 3));
            enq.delete();
            doneq.delete();
            send_syms(n, s, 1'b1);
            #1;
            checks++;
            if (b.sym_ready_o !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL flush_state: got ready=%b busy=%b required 0 1", b.sym_ready_o, busy);
            end
            @(negedge clk);
            repeat (11) @(negedge clk);
            checks++;
            if (enq.size() != n) begin
                errors++;
                $display("FAIL stream_count%0d: got %0d required %0d", r, enq.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    checks++;
                    if (enq[i].symb != s[i] || enq[i].lane != (lane_model + i) % 4 ||
                        enq[i].cyc != enq[0].cyc + i) begin
                        errors++;
                        $display("FAIL stream_sym%0d_%0d: got s=%0d l=%0d c=%0d required s=%0d l=%0d c=%0d",
                                 r, i, enq[i].symb, enq[i].lane, enq[i].cyc,
                                 s[i], (lane_model + i) % 4, enq[0].cyc + i);
                    end
                end
                checks++;
                if (doneq.size() != 1 || doneq[0] != enq[n-1].cyc + FC) begin
                    errors++;
                    $display("FAIL stream_done%0d: got %0d pulses first at %0d required 1 at %0d",
                             r, doneq.size(), (doneq.size() > 0) ? doneq[0] : -1, enq[n-1].cyc + FC);
                end
            end
            lane_model = (lane_model + n) % 4;
            checks++;
            if (b.sym_ready_o !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL stream_back_to_run: got ready=%b busy=%b required 1 0", b.sym_ready_o, busy);
            end
        end
    endtask

    task automatic test_reset_midload();
        tbl = '{100, 200, 300, 424};
        do_start();
        feed(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({b.dp_freq_wr_o, b.dp_en_o, busy, done, err, b.dp_freq_o, b.dp_cum_freq_o, b.dp_symb_o, b.dp_lane_o} !== '0) begin
            errors++;
            $display("FAIL midload_reset: got wr=%b busy=%b freq=%0d cum=%0d symb=%0d required 0",
                     b.dp_freq_wr_o, busy, b.dp_freq_o, b.dp_cum_freq_o, b.dp_symb_o);
        end
        wrq.delete();
        b.freq_valid_i = 1'b1;
        b.freq_data_i  = 11'd300;
        repeat (10) @(negedge clk);
        #1;
        checks++;
        if (wrq.size() != 0 || b.freq_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL midload_idle: got wr=%0d ready=%b required 0 0", wrq.size(), b.freq_ready_o);
        end
        b.freq_valid_i = 1'b0;
        @(negedge clk);
        do_start();
        feed(4);
        repeat (8) @(negedge clk);
        checks++;
        if (wrq.size() != 4 || wrq[0].symb != 0 || wrq[0].cum != 0 || wrq[3].cum != 600 || err !== 1'b0) begin
            errors++;
            $display("FAIL midload_reload: got n=%0d idx0=%0d err=%b required 4 0 0",
                     wrq.size(), (wrq.size() > 0) ? wrq[0].symb : -1, err);
        end
    endtask

    task automatic test_restart_in_run();
        enq.delete();
        b.sym_valid_i = 1'b1;
        b.sym_i       = 2'd1;
        cfg_start     = 1'b1;
        #1;
        checks++;
        if (b.sym_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_prio: got ready=%b required 0", b.sym_ready_o);
        end
        @(negedge clk);
        cfg_start = 1'b0;
        b.sym_valid_i = 1'b0;
        lane_model = 0;
        checks++;
        if (busy !== 1'b1 || enq.size() != 0) begin
            errors++;
            $display("FAIL restart_load: got busy=%b en=%0d required 1 0", busy, enq.size());
        end
        rand_valid_table();
        feed(4);
        repeat (8) @(negedge clk);
        checks++;
        if (err !== 1'b0 || b.sym_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL restart_run: got err=%b ready=%b required 0 1", err, b.sym_ready_o);
        end
    endtask

    task automatic test_stats();
        int s[8];
        int exp_sym, exp_stall;
        for (int i = 0; i < 8; i++) s[i] = int'($urandom_range(0, 3));
        enq.delete();
        force_low     = 1'b1;
        b.sym_valid_i = 1'b1;
        b.sym_last_i  = 1'b0;
        repeat (3) @(negedge clk);
        force_low = 1'b0;
        send_syms(4, s, 1'b0);
        @(negedge clk);
`ifdef RANS_SCHED_STATS_EN
        exp_sym = 4;
        exp_stall = 3;
`else
        exp_sym = 0;
        exp_stall = 0;
`endif
        checks++;
        if (sym_cnt !== 32'(exp_sym) || stall_cnt !== 32'(exp_stall)) begin
            errors++;
            $display("FAIL stats: got sym=%0d stall=%0d required %0d %0d", sym_cnt, stall_cnt, exp_sym, exp_stall);
        end
        checks++;
        if (enq.size() != 4 || enq[0].lane != lane_model || enq[3].lane != (lane_model + 3) % 4) begin
            errors++;
            $display("FAIL stats_lanes: got n=%0d required 4 starting at lane %0d", enq.size(), lane_model);
        end
        lane_model = (lane_model + 4) % 4;
    endtask

    initial begin
        rst = 1'b1;
        cfg_start = 1'b0;
        force_low = 1'b0;
        b.freq_valid_i = 1'b0;
        b.freq_data_i  = '0;
        b.sym_valid_i  = 1'b0;
        b.sym_i        = '0;
        b.sym_last_i   = 1'b0;
        @(negedge clk);
        test_reset();
        test_load();
        test_stream();
        test_error();
        test_stream();
        test_reset_midload();
        test_restart_in_run();
        test_stats();
        test_stream();
        checks++;
        if (both_hi != 0) begin
            errors++;
            $display("FAIL wr_en_exclusive: got %0d overlapping cycles required 0", both_hi);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
